// File: rtl/period_meter_if.sv
// Signal-under-test and measurement results of the period meter.
// The slave side is the meter; the master side is whoever feeds and observes it.
interface period_meter_if #(
    parameter int CNT_W = 26
);
    logic             sigIn;
    logic [CNT_W-1:0] period;
    logic             periodValid;
    logic             timeout;
    logic             glitch;
    logic             locked;

    modport master (
        output sigIn,
        input  period, periodValid, timeout, glitch, locked
    );

    modport slave (
        input  sigIn,
        output period, periodValid, timeout, glitch, locked
    );
endinterface

// File: rtl/period_meter.sv
// Measures rising-edge spacing of a slow asynchronous signal in clkIn cycles,
// rejecting glitches and flagging loss of edges with a timeout pulse.
module period_meter #(
    parameter int CNT_W       = 26,
    parameter int TIMEOUT     = 50000000,
    parameter int MIN_PERIOD  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic clkIn,
    input  logic rst,
    period_meter_if.slave bus
);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t state, stateNext;

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   prevQ;
    logic                   rise;

    logic [CNT_W-1:0] count, countNext, countInc;
    logic [CNT_W-1:0] periodQ, periodNext;
    logic             validQ, validNext;
    logic             timeoutQ, timeoutNext;
    logic             glitchQ, glitchNext;

    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            syncQ <= '0;
            prevQ <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], bus.sigIn};
            prevQ <= syncQ[SYNC_STAGES-1];
        end
    end

    assign rise     = syncQ[SYNC_STAGES-1] & ~prevQ;
    assign countInc = count + ONE_C;

    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            periodQ  <= '0;
            validQ   <= 1'b0;
            timeoutQ <= 1'b0;
            glitchQ  <= 1'b0;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            periodQ  <= periodNext;
            validQ   <= validNext;
            timeoutQ <= timeoutNext;
            glitchQ  <= glitchNext;
        end
    end

    always_comb begin
        stateNext   = state;
        countNext   = count;
        periodNext  = periodQ;
        validNext   = 1'b0;
        timeoutNext = 1'b0;
        glitchNext  = 1'b0;
        unique case (state)
            IDLE: begin
                countNext = '0;
                if (rise) stateNext = MEASURE;
            end
            MEASURE: begin
                // An accepted edge beats the timeout threshold on the same cycle
                if (rise && countInc >= MIN_C) begin
                    periodNext = countInc;
                    validNext  = 1'b1;
                    countNext  = '0;
                end else begin
                    countNext  = countInc;
                    glitchNext = rise;
                    if (countInc == TIMEOUT_C) begin
                        timeoutNext = 1'b1;
                        stateNext   = IDLE;
                        countNext   = '0;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                countNext = '0;
            end
        endcase
    end

    assign bus.period      = periodQ;
    assign bus.periodValid = validQ;
    assign bus.timeout     = timeoutQ;
    assign bus.glitch      = glitchQ;
    assign bus.locked      = (state == MEASURE);
endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: spacing, bridging, timeout, glitch,
// threshold tie and asynchronous reset, with hand-computed expectations.
module tb_period_meter;
    logic clkIn = 1'b0;
    logic rst   = 1'b1;

    always #5 clkIn = ~clkIn;

    period_meter_if #(.CNT_W(26)) bus ();

    period_meter #(
        .CNT_W(26),
        .TIMEOUT(100),
        .MIN_PERIOD(4),
        .SYNC_STAGES(2)
    ) dut (
        .clkIn(clkIn),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    int          cyc = 0;
    int          nValid = 0;
    int          nGlitch = 0;
    int          nTimeout = 0;
    int          lastTimeoutCyc = 0;
    logic [25:0] lastPer = '0;
    int          perQ[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(posedge clkIn) cyc <= cyc + 1;

    always begin
        @(posedge clkIn);
        #1;
        if (bus.periodValid) begin
            nValid++;
            lastPer = bus.period;
            perQ.push_back(int'(bus.period));
        end
        if (bus.glitch) nGlitch++;
        if (bus.timeout) begin
            nTimeout++;
            lastTimeoutCyc = cyc;
        end
    end

    task automatic drive(input logic v, input int n);
        bus.sigIn = v;
        repeat (n) @(negedge clkIn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, g0, t0, rCyc;
        int expQ[4];
        bus.sigIn = 1'b0;
        repeat (2) @(negedge clkIn);
        chk("rst_period", bus.period, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_valid", bus.periodValid, 0);
        rst = 1'b0;
        repeat (3) @(negedge clkIn);

        // 1: steady 6-cycle wave
        v0 = nValid;
        drive(1'b1, 3);
        chk("t1_locked", bus.locked, 1);
        chk("t1_arm_novalid", nValid - v0, 0);
        drive(1'b0, 3);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3);
            drive(1'b0, 3);
        end
        chk("t1_nvalid", nValid - v0, 4);
        chk("t1_period", lastPer, 6);

        // 2: 6 -> 20 change; bridging rise spacing is 3 high + 10 low
        v0 = nValid;
        perQ.delete();
        expQ[0] = 6;
        expQ[1] = 3 + 10;
        expQ[2] = 20;
        expQ[3] = 20;
        rCyc = 0;
        drive(1'b1, 3);
        drive(1'b0, 10);
        for (int i = 0; i < 3; i++) begin
            rCyc = cyc;
            drive(1'b1, 10);
            drive(1'b0, 10);
        end
        chk("t2_nvalid", nValid - v0, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < perQ.size()) chk($sformatf("t2_per%0d", i), perQ[i], expQ[i]);
        end

        // 3: edges stop; timeout 100 cycles after last processed rise
        t0 = nTimeout;
        for (int i = 0; i < 200 && nTimeout == t0; i++) @(negedge clkIn);
        chk("t3_timeout_cnt", nTimeout - t0, 1);
        chk("t3_timeout_cyc", lastTimeoutCyc, rCyc + 3 + 100);
        chk("t3_locked", bus.locked, 0);
        chk("t3_period_held", bus.period, 20);
        @(negedge clkIn);
        chk("t3_pulse_width", bus.timeout, 0);

        // 4: glitch 2 cycles after rise A, true rise 9 after A
        v0 = nValid;
        g0 = nGlitch;
        perQ.delete();
        drive(1'b1, 3);
        drive(1'b0, 3);
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 2);
        drive(1'b0, 5);
        // 5: next rise exactly 100 cycles later hits the timeout threshold
        t0 = nTimeout;
        drive(1'b1, 1);
        drive(1'b0, 99);
        chk("t4_glitch", nGlitch - g0, 1);
        chk("t4_nvalid", nValid - v0, 2);
        if (perQ.size() > 1) chk("t4_full_spacing", perQ[1], 9);
        drive(1'b1, 1);
        drive(1'b0, 5);
        chk("t5_period", lastPer, 100);
        chk("t5_no_timeout", nTimeout - t0, 0);
        chk("t5_locked", bus.locked, 1);

        // 6: async reset between clock edges
        @(negedge clkIn);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_period", bus.period, 0);
        chk("t6_rst_locked", bus.locked, 0);
        @(negedge clkIn);
        rst = 1'b0;
        repeat (3) @(negedge clkIn);
        v0 = nValid;
        drive(1'b1, 3);
        chk("t6_arm_locked", bus.locked, 1);
        drive(1'b0, 4);
        chk("t6_arm_novalid", nValid - v0, 0);
        drive(1'b1, 1);
        drive(1'b0, 4);
        chk("t6_nvalid", nValid - v0, 1);
        chk("t6_period", lastPer, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
